// File: rtl/logic_unit_pkg.sv
// Shared definitions for the serial logic unit: op codes, FSM states and
// the per-bit operation used by every slice.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_ANDN  = 3'b100;
  localparam logic [2:0] OP_NAND  = 3'b101;
  localparam logic [2:0] OP_XNOR  = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the word splits into a whole number of non-empty slices.
  function automatic bit width_ok(int data_w, int slice_w);
    return (slice_w > 0) && (data_w >= slice_w) && ((data_w % slice_w) == 0);
  endfunction

  function automatic logic bit_op(logic [2:0] op, logic x, logic y);
    logic r;
    case (op)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_XOR:   r = x ^ y;
      OP_NOR:   r = ~(x | y);
      OP_ANDN:  r = x & ~y;
      OP_NAND:  r = ~(x & y);
      OP_XNOR:  r = ~(x ^ y);
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/slice_logic.sv
// Combinational logic operation on one SLICE_W-bit slice of the operands.
module slice_logic
  import logic_unit_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [2:0]         op,
  input  logic [SLICE_W-1:0] sa,
  input  logic [SLICE_W-1:0] sb,
  output logic [SLICE_W-1:0] sy
);

  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
      assign sy[gi] = bit_op(op, sa[gi], sb[gi]);
    end
  endgenerate

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE_W slice per cycle, LSB first,
// with a start/ready/done handshake and a zero flag.
module serial_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (!width_ok(DATA_W, SLICE_W)) begin : g_bad_width
      $fatal(1, "serial_logic_unit: DATA_W must be a non-zero multiple of SLICE_W");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   a_reg, b_reg, result_reg;
  logic [2:0]          op_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                nz_reg, zero_reg;
  logic [SLICE_W-1:0]  sa, sb, sy;
  logic                accept, last_slice;

  assign ready      = (state_reg != ST_RUN);
  assign done       = (state_reg == ST_DONE);
  assign result     = result_reg;
  assign zero       = zero_reg;
  assign accept     = start & ready;
  assign last_slice = (idx_reg == LAST_IDX);

  assign sa = a_reg[idx_reg*SLICE_W +: SLICE_W];
  assign sb = b_reg[idx_reg*SLICE_W +: SLICE_W];

  slice_logic #(.SLICE_W(SLICE_W)) u_slice (
    .op (op_reg),
    .sa (sa),
    .sb (sb),
    .sy (sy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Accept and RUN never coincide: ready is low throughout RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_AND;
      idx_reg    <= '0;
      nz_reg     <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      op_reg     <= op;
      idx_reg    <= '0;
      nz_reg     <= 1'b0;
      result_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      result_reg[idx_reg*SLICE_W +: SLICE_W] <= sy;
      nz_reg <= nz_reg | (|sy);
      if (last_slice) begin
        idx_reg  <= '0;
        zero_reg <= ~(nz_reg | (|sy));
      end else begin
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: vector table on the default build,
// handshake corner cases, and a parameter sweep against a bitwise model.
module tb_serial_logic_unit;
  import logic_unit_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        ready, done, zero;
  logic [31:0] result;

  serial_logic_unit #(.DATA_W(32), .SLICE_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .zero    (zero)
  );

  logic        sw_start;
  logic [2:0]  sw_op;
  logic [63:0] sw_a, sw_b;
  logic        sw_ready [3];
  logic        sw_done  [3];
  logic        sw_zero  [3];
  logic [63:0] sw_res   [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int DW = (gi == 0) ? 32 : (gi == 1) ? 64 : 16;
      localparam int SW = (gi == 0) ? 32 : (gi == 1) ? 16 : 1;
      logic [DW-1:0] res;
      serial_logic_unit #(.DATA_W(DW), .SLICE_W(SW)) u_sw (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (sw_start),
        .op      (sw_op),
        .a       (sw_a[DW-1:0]),
        .b       (sw_b[DW-1:0]),
        .ready   (sw_ready[gi]),
        .done    (sw_done[gi]),
        .result  (res),
        .zero    (sw_zero[gi])
      );
      assign sw_res[gi] = 64'(res);
    end
  endgenerate

  function automatic int sw_width(int i);
    return (i == 0) ? 32 : (i == 1) ? 64 : 16;
  endfunction

  function automatic int sw_nslice(int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 16;
  endfunction

  function automatic logic [63:0] model(logic [2:0] o, logic [63:0] x, logic [63:0] y, int w);
    logic [63:0] r, mask;
    case (o)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = x & ~y;
      3'b101:  r = ~(x & y);
      3'b110:  r = ~(x ^ y);
      default: r = x;
    endcase
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return r & mask;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clock); #1;
    start = 1'b0;
    op    = 3'(($urandom));
    a     = 32'($urandom);
    b     = 32'($urandom);
  endtask

  // Cycles from the accept edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = c;
        return;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int   lat;
    logic seen;
    logic got [3];
    logic [63:0] ea, eb;

    vecs[0] = '{"and",   OP_AND,   32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 1'b0};
    vecs[1] = '{"xor_z", OP_XOR,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[2] = '{"nor",   OP_NOR,   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{"or",    OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[4] = '{"nand",  OP_NAND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5] = '{"passa", OP_PASSA, 32'hA5A5_A5A5, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0};
    vecs[6] = '{"andn",  OP_ANDN,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
    vecs[7] = '{"xnor",  OP_XNOR,  32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[8] = '{"xor",   OP_XOR,   32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 1'b0};

    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    sw_start = 1'b0; sw_op = 3'd0; sw_a = '0; sw_b = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    check("rst_ready",  64'(ready),  64'd1);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero",   64'(zero),   64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("idle_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, 64'(ready), 64'd0);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd4);
      check({vecs[i].name, "_result"}, 64'(result), 64'(vecs[i].res));
      check({vecs[i].name, "_zero"}, 64'(zero), 64'(vecs[i].z));
      @(posedge clock); #1;
      check({vecs[i].name, "_pulse"}, 64'(done), 64'd0);
      check({vecs[i].name, "_hold"}, 64'(result), 64'(vecs[i].res));
      $display("[TB] vec %s op=%0d a=%h b=%h result=%h zero=%0d lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, result, zero, lat);
    end

    // Back-to-back: second start held during the first op's DONE cycle.
    issue(OP_ANDN, 32'hFFFF_FFFF, 32'h0000_FFFF);
    wait_done(lat);
    check("b2b_first_lat", 64'(lat), 64'd4);
    check("b2b_first_res", 64'(result), 64'hFFFF_0000);
    check("b2b_first_zero", 64'(zero), 64'd0);
    check("b2b_ready_in_done", 64'(ready), 64'd1);
    issue(OP_XNOR, 32'h0000_0001, 32'h0000_0001);
    check("b2b_second_accepted", 64'(ready), 64'd0);
    seen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      if (c < 4 && done) seen = 1'b1;
      if (c == 1) begin
        start = 1'b1; op = OP_PASSA; a = 32'h1234_5678; b = 32'h0;
      end
      if (c == 2) start = 1'b0;
    end
    check("b2b_no_early_done", 64'(seen), 64'd0);
    check("b2b_second_done_at8", 64'(done), 64'd1);
    check("b2b_second_res", 64'(result), 64'hFFFF_FFFF);
    check("b2b_second_zero", 64'(zero), 64'd0);
    @(posedge clock); #1;
    check("b2b_midrun_ignored_done", 64'(done), 64'd0);
    check("b2b_midrun_ignored_ready", 64'(ready), 64'd1);
    $display("[TB] back-to-back ANDN then XNOR result=%h", result);

    // Asynchronous reset two cycles into an OR.
    issue(OP_OR, 32'h1122_3344, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_partial_res", 64'(result), 64'h0000_3344);
    #2 reset_n = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero",   64'(zero),   64'd1);
    check("abort_ready",  64'(ready),  64'd1);
    check("abort_done",   64'(done),   64'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    issue(OP_AND, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    wait_done(lat);
    check("after_abort_lat", 64'(lat), 64'd4);
    check("after_abort_res", 64'(result), 64'h0F0F_0F0F);
    $display("[TB] reset mid-op then AND result=%h lat=%0d", result, lat);

    // Parameter sweep: all ops on (32,32), (64,16), (16,1).
    for (int o = 0; o < 8; o++) begin
      ea = {32'($urandom), 32'($urandom)};
      eb = {32'($urandom), 32'($urandom)};
      sw_op = 3'(o); sw_a = ea; sw_b = eb; sw_start = 1'b1;
      @(posedge clock); #1;
      sw_start = 1'b0; sw_a = ~ea; sw_b = ~eb; sw_op = ~sw_op;
      for (int i = 0; i < 3; i++) got[i] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
          if (sw_done[i] && !got[i]) begin
            got[i] = 1'b1;
            check($sformatf("sweep%0d_op%0d_lat", i, o), 64'(c), 64'(sw_nslice(i)));
            check($sformatf("sweep%0d_op%0d_res", i, o), sw_res[i],
                  model(3'(o), ea, eb, sw_width(i)));
            check($sformatf("sweep%0d_op%0d_zero", i, o), 64'(sw_zero[i]),
                  64'(model(3'(o), ea, eb, sw_width(i)) == 64'd0));
            $display("[TB] sweep w=%0d n=%0d op=%0d result=%h lat=%0d",
                     sw_width(i), sw_nslice(i), o, sw_res[i], c);
          end
        end
      end
      for (int i = 0; i < 3; i++)
        if (!got[i]) check($sformatf("sweep%0d_op%0d_timeout", i, o), 64'd0, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
